// File: rtl/deglitch_ctrl.sv
// Sequencing controller for the SCL/SDA deglitch filter pair: maps the speed mode to the
// DS/BYP controls and runs a preset/settle sequence when the bus is idle.
module deglitch_ctrl #(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned IDLE_CYC   = 8,
    parameter int unsigned CW         = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] MODE,
    input  logic       MODE_WR,
    input  logic       SCL_F,
    input  logic       SDA_F,
    output logic       DS,
    output logic       BYP,
    output logic       SB,
    output logic       VALID,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_PRESET    = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_e;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_CYC - 1);

    // Returns {ds, byp} for a speed mode.
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        case (m)
            2'd2:    map_mode = 2'b10;
            2'd3:    map_mode = 2'b11;
            default: map_mode = 2'b00;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  cur_mode_q, cur_mode_d;
    logic [1:0]  pend_mode_q, pend_mode_d;
    logic        pend_q, pend_d;
    logic        ds_q, ds_d;
    logic        byp_q, byp_d;
    logic        sb_q, sb_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic        bus_idle_s;

    // Two-flop synchronizers; they clear to the idle level so reset never looks like bus activity.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= SCL_F;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= SDA_F;
            sda_s2_q <= sda_s1_q;
        end
    end

    assign bus_idle_s = scl_s2_q & sda_s2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_PRESET;
            cnt_q       <= '0;
            cur_mode_q  <= 2'd0;
            pend_mode_q <= 2'd0;
            pend_q      <= 1'b0;
            ds_q        <= 1'b0;
            byp_q       <= 1'b0;
            sb_q        <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_mode_q  <= cur_mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            ds_q        <= ds_d;
            byp_q       <= byp_d;
            sb_q        <= sb_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_mode_d  = cur_mode_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        ds_d        = ds_q;
        byp_d       = byp_q;

        // Outside RUN a write only queues the mode; the idle counter keeps going.
        if (MODE_WR && (state_q != ST_RUN)) begin
            pend_mode_d = MODE;
            pend_d      = 1'b1;
        end else begin
            pend_mode_d = pend_mode_q;
        end

        case (state_q)
            ST_PRESET: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = pend_d ? ST_WAIT_IDLE : ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (MODE_WR && (MODE != cur_mode_q)) begin
                    pend_mode_d = MODE;
                    pend_d      = 1'b1;
                    state_d     = ST_WAIT_IDLE;
                    cnt_d       = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT_IDLE: begin
                if (!bus_idle_s) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cur_mode_d     = pend_mode_q;
                    {ds_d, byp_d}  = map_mode(pend_mode_q);
                    pend_d         = MODE_WR;
                    state_d        = ST_PRESET;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_PRESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs decoded from the next state so they are registered alongside it.
    always_comb begin
        sb_d    = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        case (state_d)
            ST_PRESET: begin
                sb_d    = 1'b0;
                valid_d = 1'b0;
            end
            ST_SETTLE:    valid_d = 1'b0;
            ST_RUN:       busy_d  = 1'b0;
            ST_WAIT_IDLE: busy_d  = 1'b1;
            default: begin
                sb_d    = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign DS    = ds_q;
    assign BYP   = byp_q;
    assign SB    = sb_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_deglitch_ctrl.sv
// Directed bench for deglitch_ctrl with SETTLE_CYC=4, IDLE_CYC=3.
module tb_deglitch_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] MODE = 2'd0;
    logic       MODE_WR = 1'b0;
    logic       SCL_F = 1'b1;
    logic       SDA_F = 1'b1;
    logic       DS, BYP, SB, VALID, BUSY;

    deglitch_ctrl #(.SETTLE_CYC(4), .IDLE_CYC(3), .CW(8)) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .MODE_WR(MODE_WR),
        .SCL_F(SCL_F), .SDA_F(SDA_F),
        .DS(DS), .BYP(BYP), .SB(SB), .VALID(VALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic       wr;
        logic [1:0] mode;
        logic [4:0] exp;   // {DS, BYP, SB, VALID, BUSY} after edge cyc
    } vec_t;

    vec_t vec[14];
    int   edge_idx = -1;
    int   n_total = 0;
    int   n_pass = 0;

    task automatic tick();
        @(posedge CLK);
        edge_idx++;
        @(negedge CLK);
    endtask

    task automatic tick_to(input int target);
        while (edge_idx < target) tick();
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        n_total++;
        if ({DS, BYP, SB, VALID, BUSY} === exp)
            n_pass++;
        else
            $display("FAIL %s edge %0d: {DS,BYP,SB,VALID,BUSY} got %b expected %b",
                     name, edge_idx, {DS, BYP, SB, VALID, BUSY}, exp);
    endtask

    task automatic run_table(input int n_rows);
        for (int r = 0; r < n_rows; r++) begin
            tick_to(vec[r].cyc - 1);
            MODE    = vec[r].mode;
            MODE_WR = vec[r].wr;
            tick();
            MODE_WR = 1'b0;
            check($sformatf("vec%0d", r), vec[r].exp);
        end
    endtask

    initial begin
        vec[0]  = '{0,  1'b0, 2'd0, 5'b00001};
        vec[1]  = '{2,  1'b0, 2'd0, 5'b00001};
        vec[2]  = '{3,  1'b0, 2'd0, 5'b00101};
        vec[3]  = '{6,  1'b0, 2'd0, 5'b00101};
        vec[4]  = '{7,  1'b0, 2'd0, 5'b00110};
        vec[5]  = '{19, 1'b0, 2'd0, 5'b00110};
        vec[6]  = '{20, 1'b1, 2'd2, 5'b00111};
        vec[7]  = '{22, 1'b0, 2'd0, 5'b00111};
        vec[8]  = '{23, 1'b0, 2'd0, 5'b10001};
        vec[9]  = '{26, 1'b0, 2'd0, 5'b10001};
        vec[10] = '{27, 1'b0, 2'd0, 5'b10101};
        vec[11] = '{30, 1'b0, 2'd0, 5'b10101};
        vec[12] = '{31, 1'b0, 2'd0, 5'b10110};
        vec[13] = '{35, 1'b0, 2'd0, 5'b10110};

        // Reset state
        RST = 1'b1;
        tick(); tick(); tick();
        check("reset", 5'b00001);
        RST = 1'b0;
        edge_idx = -1;

        // Power-up sequence and reconfiguration to mode 2 from RUN
        run_table(14);

        // Mode 3 requested while SDA toggles: no apply until the bus stays idle
        for (int i = 0; i < 20; i++) begin
            SDA_F   = (i % 2 == 0) ? 1'b0 : 1'b1;
            MODE    = 2'd3;
            MODE_WR = (i == 0);
            tick();
            MODE_WR = 1'b0;
            check($sformatf("toggle%0d", i), 5'b10111);
        end
        SDA_F = 1'b0;
        tick();                         // edge 56
        check("toggle_last_low", 5'b10111);
        SDA_F = 1'b1;
        tick_to(60);
        check("idle_not_yet", 5'b10111);
        tick();                         // edge 61
        check("apply_mode3", 5'b11001);
        tick_to(68);
        check("mode3_settle", 5'b11101);
        tick();                         // edge 69
        check("mode3_run", 5'b11110);

        // Two writes while waiting on a busy bus: last write wins, one preset only
        SDA_F = 1'b0;
        tick();                         // edge 70
        MODE = 2'd2; MODE_WR = 1'b1;
        tick();                         // edge 71
        MODE_WR = 1'b0;
        check("wr2_wait", 5'b11111);
        tick();                         // edge 72
        MODE = 2'd1; MODE_WR = 1'b1;
        tick();                         // edge 73
        MODE_WR = 1'b0;
        check("wr1_wait", 5'b11111);
        SDA_F = 1'b1;
        tick_to(77);
        check("lastwr_before_apply", 5'b11111);
        tick();                         // edge 78
        check("lastwr_apply", 5'b00001);
        tick_to(86);
        check("lastwr_run", 5'b00110);
        tick_to(90);
        check("lastwr_single_preset", 5'b00110);

        // Writing the current mode in RUN is ignored
        MODE = 2'd1; MODE_WR = 1'b1;
        tick();                         // edge 91
        MODE_WR = 1'b0;
        check("same_mode", 5'b00110);
        tick_to(94);
        check("same_mode_later", 5'b00110);

        // Reset during SETTLE with a pending mode discards everything
        MODE = 2'd2; MODE_WR = 1'b1;
        tick();                         // edge 95
        MODE_WR = 1'b0;
        tick_to(98);
        check("rst_seq_preset", 5'b10001);
        tick_to(102);
        check("rst_seq_settle", 5'b10101);
        MODE = 2'd0; MODE_WR = 1'b1;
        tick();                         // edge 103
        MODE_WR = 1'b0;
        check("rst_seq_pend", 5'b10101);
        RST = 1'b1;
        tick();                         // edge 104
        check("rst_mid", 5'b00001);
        RST = 1'b0;
        edge_idx = -1;
        run_table(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
